// File: rtl/multi_stack.sv
// Multi-channel LIFO: NUM_CH independent stacks sharing one storage array and
// one push/pop port, with replace-top, registered pop data and error pulses.
module multi_stack #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_CH     = 4,
    parameter int CH_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH_WIDTH-1:0]   ch_sel,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [NUM_CH-1:0]     full,
    output logic [NUM_CH-1:0]     empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH     = 2**ADDR_WIDTH;
    localparam int MEM_WORDS = NUM_CH * DEPTH;
    localparam int MEM_AW    = CH_WIDTH + ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    ptr_t                  sp_q [NUM_CH];
    ptr_t                  sp_d [NUM_CH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  chValid;
    logic [CH_WIDTH-1:0]   chIdx;
    ptr_t                  curSp;
    ptr_t                  topSp;
    logic                  curFull;
    logic                  curEmpty;
    logic                  memWe;
    logic [MEM_AW-1:0]     wrAddr;
    logic [MEM_AW-1:0]     rdAddr;
    logic [DATA_WIDTH-1:0] memRdData;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            full[c]  = (sp_q[c] == ptr_t'(DEPTH));
            empty[c] = (sp_q[c] == '0);
        end
    end

    // Out-of-range channel indices fold onto channel 0 but are never acted upon.
    always_comb begin
        chValid   = ({1'b0, ch_sel} < (CH_WIDTH+1)'(NUM_CH));
        chIdx     = chValid ? ch_sel : '0;
        curSp     = sp_q[chIdx];
        topSp     = curSp - 1'b1;
        curFull   = (curSp == ptr_t'(DEPTH));
        curEmpty  = (curSp == '0);
        level     = chValid ? curSp : '0;
        rdAddr    = {chIdx, topSp[ADDR_WIDTH-1:0]};
        memRdData = mem[rdAddr];
    end

    always_comb begin
        sp_d        = sp_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        memWe       = 1'b0;
        wrAddr      = {chIdx, curSp[ADDR_WIDTH-1:0]};
        if (chValid) begin
            if (push && pop) begin
                rd_valid_d = 1'b1;
                if (curEmpty) begin
                    rd_data_d = wr_data;
                end else begin
                    rd_data_d = memRdData;
                    memWe     = 1'b1;
                    wrAddr    = {chIdx, topSp[ADDR_WIDTH-1:0]};
                end
            end else if (push) begin
                if (curFull) begin
                    overflow_d = 1'b1;
                end else begin
                    memWe        = 1'b1;
                    sp_d[chIdx]  = curSp + 1'b1;
                end
            end else if (pop) begin
                if (curEmpty) begin
                    underflow_d = 1'b1;
                end else begin
                    rd_data_d    = memRdData;
                    rd_valid_d   = 1'b1;
                    sp_d[chIdx]  = topSp;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q        <= '{default: '0};
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage has no reset; a reset only clears the pointers.
    always_ff @(posedge clk) begin
        if (memWe && !rst) begin
            mem[wrAddr] <= wr_data;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
